// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types for the ALU command sequencer: command word and sequencer states.
package alu_cmd_pkg;

    localparam int FUNC_W = 3;
    localparam int OPND_W = 4;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [OPND_W-1:0] operand;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO (module cmd_fifo): head data is combinational,
// flush clears pointers and drops any same-cycle push.
module cmd_fifo
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  cmd_t                     push_data,
    output cmd_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q;
    logic            do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            // push+pop together leaves the occupancy unchanged
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues {func, operand} commands and issues them to the ALU/accumulator stage.
// Optional CMD_SINGLE_STEP_EN adds step_mode/step for one-command-per-step issue.
module alu_cmd_sequencer
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [FUNC_W-1:0] wr_func,
    input  logic [OPND_W-1:0] wr_operand,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
`ifdef CMD_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FUNC_W-1:0] out_func,
    output logic [OPND_W-1:0] out_operand,
    output logic              busy,
    output logic              done,
    output logic              empty,
    output logic [CNT_W-1:0]  issued_cnt
);

    localparam int AW = $clog2(DEPTH);

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    cmd_t                head, wr_cmd;
    logic                full, push, fire, issue_ok, last;
    logic [AW:0]         fifo_count;

    assign wr_cmd.func    = wr_func;
    assign wr_cmd.operand = wr_operand;
    assign wr_ready       = !full;
    assign push           = wr_valid && wr_ready && !abort;

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (fire),
        .flush     (abort),
        .push_data (wr_cmd),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

`ifdef CMD_SINGLE_STEP_EN
    logic armed_q, armed_d;

    assign issue_ok = !step_mode || armed_q;

    // A step arms exactly one issue; the fire that consumes it disarms.
    always_comb begin
        armed_d = armed_q;
        if (fire) armed_d = 1'b0;
        if (step && step_mode && state_q == RUN) armed_d = 1'b1;
        if (!step_mode) armed_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset || abort) armed_q <= 1'b0;
        else                armed_q <= armed_d;
    end
`else
    assign issue_ok = 1'b1;
`endif

    // pause masks out_valid in the very cycle it rises, before the FSM moves
    assign out_valid   = (state_q == RUN) && !empty && !pause && issue_ok;
    assign fire        = out_valid && out_ready;
    assign out_func    = out_valid ? head.func    : '0;
    assign out_operand = out_valid ? head.operand : '0;
    assign busy        = (state_q == RUN) || (state_q == PAUSE);
    assign done        = (state_q == DONE);
    assign issued_cnt  = cnt_q;
    assign last        = (fifo_count == {{AW{1'b0}}, 1'b1}) && !push;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fire) cnt_d = cnt_q + 1'b1;
        case (state_q)
            IDLE:    if (start) state_d = empty ? DONE : RUN;
            RUN: begin
                if (pause)             state_d = PAUSE;
                else if (fire && last) state_d = DONE;
            end
            PAUSE:   if (!pause) state_d = RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer; step-mode scenario under CMD_SINGLE_STEP_EN.
module tb_alu_cmd_sequencer;
    import alu_cmd_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0, wr_ready;
    logic [2:0] wr_func = '0;
    logic [3:0] wr_operand = '0;
    logic       start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic       out_valid, out_ready = 1'b0;
    logic [2:0] out_func;
    logic [3:0] out_operand;
    logic       busy, done, empty;
    logic [7:0] issued_cnt;
`ifdef CMD_SINGLE_STEP_EN
    logic       step_mode = 1'b0, step = 1'b0;
`endif

    int   checks = 0, errors = 0;
    int   fire_cnt = 0, done_cnt = 0, cyc = 0, last_fire_cyc = 0, prev_fire_cyc = 0;
    cmd_t sb[$];

    alu_cmd_sequencer #(.DEPTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_func(wr_func), .wr_operand(wr_operand),
        .start(start), .pause(pause), .abort(abort),
`ifdef CMD_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_func(out_func), .out_operand(out_operand),
        .busy(busy), .done(done), .empty(empty), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every fire must match the oldest accepted write.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                fire_cnt++;
                prev_fire_cyc = last_fire_cyc;
                last_fire_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL fire_unexpected: got func=%0d op=%0h, scoreboard empty", out_func, out_operand);
                end else begin
                    cmd_t e;
                    e = sb.pop_front();
                    if ({out_func, out_operand} !== {e.func, e.operand}) begin
                        errors++;
                        $display("FAIL fire_data: got func=%0d op=%0h, expected func=%0d op=%0h",
                                 out_func, out_operand, e.func, e.operand);
                    end
                end
            end else if (!out_valid) begin
                checks++;
                if ({out_func, out_operand} !== 7'd0) begin
                    errors++;
                    $display("FAIL idle_zero: got func=%0d op=%0h, expected 0/0", out_func, out_operand);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] f, input logic [3:0] o);
        cmd_t c;
        c.func = f; c.operand = o;
        wr_valid = 1'b1; wr_func = f; wr_operand = o;
        if (wr_ready) sb.push_back(c);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 40) begin tick(); n++; end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within 40 cycles", name);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        @(negedge clk);
        checks += 8;
        if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        if (out_func !== 3'd0)     begin errors++; $display("FAIL rst_out_func: got %0d expected 0", out_func); end
        if (out_operand !== 4'd0)  begin errors++; $display("FAIL rst_out_operand: got %0d expected 0", out_operand); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (done !== 1'b0)         begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        if (empty !== 1'b1)        begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        if (wr_ready !== 1'b1)     begin errors++; $display("FAIL rst_wr_ready: got %b expected 1", wr_ready); end
        if (issued_cnt !== 8'd0)   begin errors++; $display("FAIL rst_issued_cnt: got %0d expected 0", issued_cnt); end
        tick();
    endtask

    task automatic test_midrun_reset();
        int f0;
        out_ready = 1'b0;
        wr(3'd2, 4'h9); wr(3'd4, 4'h1);
        pulse_start();
        reset = 1'b1; tick(); reset = 1'b0;
        sb.delete();
        f0 = fire_cnt;
        out_ready = 1'b1;
        repeat (3) tick();
        checks += 3;
        if (empty !== 1'b1)      begin errors++; $display("FAIL mrst_empty: got %b expected 1", empty); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL mrst_busy: got %b expected 0", busy); end
        if (fire_cnt != f0)      begin errors++; $display("FAIL mrst_fires: got %0d expected 0", fire_cnt - f0); end
        out_ready = 1'b0;
    endtask

    task automatic test_basic_run();
        int f0 = fire_cnt, d0 = done_cnt;
        out_ready = 1'b0;
        wr(3'b001, 4'h3); wr(3'b000, 4'h5);
        out_ready = 1'b1;
        pulse_start();
        wait_done("basic");
        tick();
        checks += 5;
        if (fire_cnt - f0 != 2)               begin errors++; $display("FAIL basic_fires: got %0d expected 2", fire_cnt - f0); end
        if (last_fire_cyc - prev_fire_cyc != 1) begin errors++; $display("FAIL basic_b2b: fire gap %0d expected 1", last_fire_cyc - prev_fire_cyc); end
        if (done_cnt - d0 != 1)               begin errors++; $display("FAIL basic_done_pulse: got %0d cycles expected 1", done_cnt - d0); end
        if (issued_cnt !== 8'd2)              begin errors++; $display("FAIL basic_issued: got %0d expected 2", issued_cnt); end
        if (sb.size() != 0)                   begin errors++; $display("FAIL basic_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_full_wrap();
        int f0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(3'(i), 4'(i + 1));
        out_ready = 1'b1;
        pulse_start();
        wait_done("prefill");
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(3'(7 - i), 4'((i * 5 + 2) & 15));
        checks += 2;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
        wr(3'd7, 4'hF);
        if (sb.size() != 8)    begin errors++; $display("FAIL full_ninth: got %0d entries expected 8", sb.size()); end
        f0 = fire_cnt;
        out_ready = 1'b1;
        pulse_start();
        wait_done("wrap");
        checks += 3;
        if (fire_cnt - f0 != 8)  begin errors++; $display("FAIL wrap_fires: got %0d expected 8", fire_cnt - f0); end
        if (issued_cnt !== 8'd15) begin errors++; $display("FAIL wrap_issued: got %0d expected 15", issued_cnt); end
        if (empty !== 1'b1)      begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    task automatic test_stall_pause();
        out_ready = 1'b0;
        wr(3'd5, 4'hA); wr(3'd6, 4'hB); wr(3'd3, 4'hC);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 2;
            if (out_valid !== 1'b1 || {out_func, out_operand} !== {sb[0].func, sb[0].operand}) begin
                errors++; $display("FAIL stall_head: got v=%b func=%0d op=%0h expected v=1 func=%0d op=%0h",
                                   out_valid, out_func, out_operand, sb[0].func, sb[0].operand);
            end
            if (issued_cnt !== 8'd15) begin errors++; $display("FAIL stall_issued: got %0d expected 15", issued_cnt); end
            tick();
        end
        pause = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks += 2;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL pause_valid: got %b expected 0", out_valid); end
            if (busy !== 1'b1)      begin errors++; $display("FAIL pause_busy: got %b expected 1", busy); end
            tick();
        end
        pause = 1'b0;
        out_ready = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || {out_func, out_operand} !== 7'b101_1010) begin
            errors++; $display("FAIL resume_head: got v=%b func=%0d op=%0h expected v=1 func=5 op=a", out_valid, out_func, out_operand);
        end
        tick();
        out_ready = 1'b1;
        wait_done("pause");
        checks++;
        if (issued_cnt !== 8'd18) begin errors++; $display("FAIL pause_issued: got %0d expected 18", issued_cnt); end
    endtask

    task automatic test_abort();
        int d0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(3'(i + 2), 4'(9 - i));
        pulse_start();
        tick();
        abort = 1'b1; wr_valid = 1'b1; wr_func = 3'd1; wr_operand = 4'h1;
        tick();
        abort = 1'b0; wr_valid = 1'b0;
        sb.delete();
        d0 = done_cnt;
        checks += 4;
        if (empty !== 1'b1)       begin errors++; $display("FAIL abort_empty: got %b expected 1", empty); end
        if (issued_cnt !== 8'd0)  begin errors++; $display("FAIL abort_issued: got %0d expected 0", issued_cnt); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (wr_ready !== 1'b1)    begin errors++; $display("FAIL abort_wr_ready: got %b expected 1", wr_ready); end
        repeat (3) tick();
        checks++;
        if (done_cnt != d0)       begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0); end
        pulse_start();
        checks++;
        if (done !== 1'b1)        begin errors++; $display("FAIL empty_start_done: got %b expected 1", done); end
        tick();
        checks++;
        if (done !== 1'b0)        begin errors++; $display("FAIL empty_start_done_len: got %b expected 0", done); end
    endtask

`ifdef CMD_SINGLE_STEP_EN
    task automatic test_single_step();
        int f0, d0;
        step_mode = 1'b1;
        out_ready = 1'b0;
        wr(3'd1, 4'h4); wr(3'd2, 4'h5); wr(3'd3, 4'h6);
        out_ready = 1'b1;
        f0 = fire_cnt; d0 = done_cnt;
        pulse_start();
        repeat (3) tick();
        checks++;
        if (fire_cnt != f0) begin errors++; $display("FAIL step_nofire: got %0d fires expected 0", fire_cnt - f0); end
        for (int k = 0; k < 3; k++) begin
            f0 = fire_cnt;
            step = 1'b1; tick(); step = 1'b0;
            repeat (4) tick();
            checks++;
            if (fire_cnt - f0 != 1) begin errors++; $display("FAIL step_%0d_fires: got %0d expected 1", k, fire_cnt - f0); end
        end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL step_done: got %0d pulses expected 1", done_cnt - d0); end
        step_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_midrun_reset();
        test_basic_run();
        test_full_wrap();
        test_stall_pause();
        test_abort();
`ifdef CMD_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
